// File: rtl/spike_pkg.sv
// spike_pkg: shared definitions for the spike rate decoder.
//   - default rate word / window widths
//   - saturation limit of the default-width accumulator
//   - decoder FSM state encoding
package spike_pkg;

  localparam int DEF_COUNT_W  = 5;
  localparam int DEF_WINDOW_W = 8;

  // Largest count a default-width accumulator can hold.
  localparam logic [DEF_COUNT_W-1:0] SAT_LIMIT = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit saturating up-counter with synchronous clear and a
// sticky overflow flag. The outputs are the values the counter takes on
// the coming edge (clear aside), so the owner can capture a window total
// that includes the current sample on the same edge that clears it.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   clr             clear count and overflow (wins over inc)
//   inc             attempt an increment this cycle
//   nxt_count       count after this cycle's increment
//   nxt_ovf         overflow after this cycle's increment
module sat_counter
  import spike_pkg::*;
#(
  parameter int W = DEF_COUNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] nxt_count,
  output logic         nxt_ovf
);

  logic [W-1:0] r_count;
  logic         r_ovf;
  logic         w_at_max;

  assign w_at_max  = (r_count == '1);
  assign nxt_count = (inc && !w_at_max) ? r_count + W'(1) : r_count;
  // An increment attempted while already at the limit is what flags overflow.
  assign nxt_ovf   = r_ovf | (inc & w_at_max);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (clr) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (inc) begin
      r_count <= nxt_count;
      r_ovf   <= nxt_ovf;
    end
  end

endmodule

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: counts neuron spikes over back-to-back windows of
// window_len cycles and presents each window count on a valid/ready port.
// A finished result that cannot be handed over waits in HOLD.
// Optional feature macro: SPIKE_ISI_EN adds isi_min, the minimum interval
// in cycles between consecutive spikes of the reported window.
// Ports:
//   clk, reset      clock, async active-low reset
//   enable          run windows while high, abort partial window on low
//   spike           neuron spike, sampled every cycle in COUNT
//   window_len      window length, latched at each window start
//   rate            spike count of the last completed window
//   rate_valid      rate holds an unconsumed result
//   rate_ready      consumer accepts rate on rate_valid && rate_ready
//   overflow        count saturated in the window reported on rate
//   isi_min         minimum inter-spike interval (SPIKE_ISI_EN only)
//   busy            FSM not in IDLE
//
// state | meaning
// IDLE  | waiting for enable with a non-zero window_len
// COUNT | sampling spike, timer counting down the window
// HOLD  | window finished, result parked until the output register frees
module spike_rate_decoder
  import spike_pkg::*;
#(
  parameter int WINDOW_W = DEF_WINDOW_W,
  parameter int COUNT_W  = DEF_COUNT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                spike,
  input  logic [WINDOW_W-1:0] window_len,
  output logic [COUNT_W-1:0]  rate,
  output logic                rate_valid,
  input  logic                rate_ready,
  output logic                overflow,
`ifdef SPIKE_ISI_EN
  output logic [WINDOW_W-1:0] isi_min,
`endif
  output logic                busy
);

  state_t               r_state;
  logic [WINDOW_W-1:0]  r_timer;
  logic [COUNT_W-1:0]   r_rate;
  logic                 r_rate_valid;
  logic                 r_overflow;
  logic [COUNT_W-1:0]   r_held_rate;
  logic                 r_held_ovf;

  logic                 w_free;
  logic                 w_restart;
  logic                 w_last;
  logic                 w_load_end;
  logic                 w_load_hold;
  logic                 w_clr;
  logic                 w_inc;
  logic [COUNT_W-1:0]   w_acc_nxt;
  logic                 w_acc_ovf_nxt;

  // Output register can take a result if empty or being drained this edge.
  assign w_free      = !r_rate_valid || rate_ready;
  assign w_restart   = enable && (window_len != '0);
  assign w_last      = (r_state == COUNT) && enable && (r_timer == WINDOW_W'(1));
  assign w_load_end  = w_last && w_free;
  assign w_load_hold = (r_state == HOLD) && w_free;
  assign w_clr       = ((r_state == IDLE) && w_restart)
                     || ((w_load_end || w_load_hold) && w_restart);
  assign w_inc       = (r_state == COUNT) && enable && spike;

  sat_counter #(.W(COUNT_W)) u_acc (
    .clk       (clk),
    .rst_n     (reset),
    .clr       (w_clr),
    .inc       (w_inc),
    .nxt_count (w_acc_nxt),
    .nxt_ovf   (w_acc_ovf_nxt)
  );

`ifdef SPIKE_ISI_EN
  logic [WINDOW_W-1:0]  r_isi_cnt;
  logic                 r_isi_seen;
  logic [WINDOW_W-1:0]  r_isi_win_min;
  logic [WINDOW_W-1:0]  r_held_isi;
  logic [WINDOW_W-1:0]  r_isi_min;
  logic [WINDOW_W-1:0]  w_isi_min_nxt;

  // r_isi_cnt is cycles since the previous spike, so on a spike it is the interval.
  assign w_isi_min_nxt = (w_inc && r_isi_seen && (r_isi_cnt < r_isi_win_min))
                       ? r_isi_cnt : r_isi_win_min;
  assign isi_min       = r_isi_min;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_isi_cnt     <= '0;
      r_isi_seen    <= 1'b0;
      r_isi_win_min <= '1;
      r_held_isi    <= '1;
      r_isi_min     <= '1;
    end else begin
      if (w_clr) begin
        r_isi_cnt     <= '0;
        r_isi_seen    <= 1'b0;
        r_isi_win_min <= '1;
      end else if ((r_state == COUNT) && enable) begin
        if (spike) begin
          r_isi_cnt     <= WINDOW_W'(1);
          r_isi_seen    <= 1'b1;
          r_isi_win_min <= w_isi_min_nxt;
        end else if (r_isi_cnt != '1) begin
          r_isi_cnt <= r_isi_cnt + WINDOW_W'(1);
        end
      end
      if (w_last && !w_free) r_held_isi <= w_isi_min_nxt;
      if (w_load_end)        r_isi_min  <= w_isi_min_nxt;
      else if (w_load_hold)  r_isi_min  <= r_held_isi;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_timer      <= '0;
      r_rate       <= '0;
      r_rate_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_held_rate  <= '0;
      r_held_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_restart) begin
            r_timer <= window_len;
            r_state <= COUNT;
          end
        end
        COUNT: begin
          if (!enable) begin
            r_state <= IDLE;
          end else if (r_timer == WINDOW_W'(1)) begin
            if (w_free) begin
              if (w_restart) r_timer <= window_len;
              else begin
                r_timer <= '0;
                r_state <= IDLE;
              end
            end else begin
              r_timer     <= '0;
              r_held_rate <= w_acc_nxt;
              r_held_ovf  <= w_acc_ovf_nxt;
              r_state     <= HOLD;
            end
          end else begin
            r_timer <= r_timer - WINDOW_W'(1);
          end
        end
        HOLD: begin
          if (w_free) begin
            if (w_restart) begin
              r_timer <= window_len;
              r_state <= COUNT;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase

      // A new result wins over the accept clearing rate_valid on the same edge.
      if (w_load_end) begin
        r_rate       <= w_acc_nxt;
        r_overflow   <= w_acc_ovf_nxt;
        r_rate_valid <= 1'b1;
      end else if (w_load_hold) begin
        r_rate       <= r_held_rate;
        r_overflow   <= r_held_ovf;
        r_rate_valid <= 1'b1;
      end else if (rate_ready) begin
        r_rate_valid <= 1'b0;
      end
    end
  end

  assign rate       = r_rate;
  assign rate_valid = r_rate_valid;
  assign overflow   = r_overflow;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder. Inputs change 1 time unit after
// the rising edge; outputs are checked at that same point.
module tb_spike_rate_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       spike = 1'b0;
  logic [7:0] window_len = 8'd0;
  logic [4:0] rate;
  logic       rate_valid;
  logic       rate_ready = 1'b0;
  logic       overflow;
  logic       busy;
`ifdef SPIKE_ISI_EN
  logic [7:0] isi_min;
`endif

  int n_checks = 0;
  int n_errors = 0;

  spike_rate_decoder #(.WINDOW_W(8), .COUNT_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .spike      (spike),
    .window_len (window_len),
    .rate       (rate),
    .rate_valid (rate_valid),
    .rate_ready (rate_ready),
    .overflow   (overflow),
`ifdef SPIKE_ISI_EN
    .isi_min    (isi_min),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    enable     = 1'b0;
    spike      = 1'b0;
    rate_ready = 1'b0;
    window_len = 8'd0;
    reset      = 1'b0;
    #2;
    reset      = 1'b1;
  endtask

  initial begin
    // Reset values
    do_reset();
    #1;
    check_eq("rst_rate", 32'(rate), 0);
    check_eq("rst_valid", 32'(rate_valid), 0);
    check_eq("rst_ovf", 32'(overflow), 0);
    check_eq("rst_busy", 32'(busy), 0);
`ifdef SPIKE_ISI_EN
    check_eq("rst_isi", 32'(isi_min), 255);
`endif

    // Window of 4, spike always high, back-to-back results
    window_len = 8'd4; spike = 1'b1; rate_ready = 1'b1; enable = 1'b1;
    tick(1);
    check_eq("w4_start_busy", 32'(busy), 1);
    check_eq("w4_start_valid", 32'(rate_valid), 0);
    tick(3);
    check_eq("w4_e3_valid", 32'(rate_valid), 0);
    tick(1);
    check_eq("w4_e4_valid", 32'(rate_valid), 1);
    check_eq("w4_e4_rate", 32'(rate), 4);
    check_eq("w4_e4_ovf", 32'(overflow), 0);
`ifdef SPIKE_ISI_EN
    check_eq("w4_e4_isi", 32'(isi_min), 1);
`endif
    tick(1);
    check_eq("w4_e5_valid", 32'(rate_valid), 0);
    check_eq("w4_e5_busy", 32'(busy), 1);
    tick(3);
    check_eq("w4_e8_valid", 32'(rate_valid), 1);
    check_eq("w4_e8_rate", 32'(rate), 4);

    // Window of 10, spikes on samples 3, 6, 9
    do_reset();
    window_len = 8'd10; rate_ready = 1'b1; enable = 1'b1;
    tick(1);
    for (int i = 1; i <= 10; i++) begin
      spike = (i % 3 == 0);
      tick(1);
    end
    spike = 1'b0;
    check_eq("w10_valid", 32'(rate_valid), 1);
    check_eq("w10_rate", 32'(rate), 3);
    check_eq("w10_ovf", 32'(overflow), 0);
`ifdef SPIKE_ISI_EN
    check_eq("w10_isi", 32'(isi_min), 3);
`endif

    // Saturation, then an empty window
    do_reset();
    window_len = 8'd40; spike = 1'b1; rate_ready = 1'b1; enable = 1'b1;
    tick(1);
    tick(40);
    spike = 1'b0;
    check_eq("sat_valid", 32'(rate_valid), 1);
    check_eq("sat_rate", 32'(rate), 31);
    check_eq("sat_ovf", 32'(overflow), 1);
    tick(1);
    check_eq("sat_drain_valid", 32'(rate_valid), 0);
    tick(39);
    check_eq("empty_valid", 32'(rate_valid), 1);
    check_eq("empty_rate", 32'(rate), 0);
    check_eq("empty_ovf", 32'(overflow), 0);
`ifdef SPIKE_ISI_EN
    check_eq("empty_isi", 32'(isi_min), 255);
`endif

    // Backpressure across two windows of 4
    do_reset();
    window_len = 8'd4; spike = 1'b1; rate_ready = 1'b0; enable = 1'b1;
    tick(1);
    tick(4);
    check_eq("bp_first_valid", 32'(rate_valid), 1);
    check_eq("bp_first_rate", 32'(rate), 4);
    tick(2);
    spike = 1'b0;
    tick(2);
    check_eq("bp_hold_busy", 32'(busy), 1);
    check_eq("bp_hold_rate", 32'(rate), 4);
    check_eq("bp_hold_valid", 32'(rate_valid), 1);
    spike = 1'b1;
    tick(1);
    check_eq("bp_hold2_rate", 32'(rate), 4);
    check_eq("bp_hold2_busy", 32'(busy), 1);
    rate_ready = 1'b1;
    tick(1);
    rate_ready = 1'b0;
    check_eq("bp_load_valid", 32'(rate_valid), 1);
    check_eq("bp_load_rate", 32'(rate), 2);
    check_eq("bp_load_ovf", 32'(overflow), 0);
    check_eq("bp_load_busy", 32'(busy), 1);
    tick(1);
    check_eq("bp_stable_rate", 32'(rate), 2);
    check_eq("bp_stable_valid", 32'(rate_valid), 1);

    // Abort at sample 2 of a 6-cycle window, then zero length
    do_reset();
    window_len = 8'd6; spike = 1'b1; rate_ready = 1'b1; enable = 1'b1;
    tick(2);
    enable = 1'b0;
    tick(1);
    check_eq("abort_busy", 32'(busy), 0);
    check_eq("abort_valid", 32'(rate_valid), 0);
    tick(6);
    check_eq("abort_late_valid", 32'(rate_valid), 0);
    window_len = 8'd0; enable = 1'b1;
    tick(2);
    check_eq("zero_len_busy", 32'(busy), 0);

    // window_len change mid-window only applies at the next start
    do_reset();
    window_len = 8'd4; spike = 1'b1; rate_ready = 1'b1; enable = 1'b1;
    tick(1);
    window_len = 8'd2;
    tick(3);
    check_eq("len_chg_e3_valid", 32'(rate_valid), 0);
    tick(1);
    check_eq("len_chg_e4_valid", 32'(rate_valid), 1);
    check_eq("len_chg_e4_rate", 32'(rate), 4);
    tick(1);
    check_eq("len_chg_e5_valid", 32'(rate_valid), 0);
    tick(1);
    check_eq("len_chg_e6_valid", 32'(rate_valid), 1);
    check_eq("len_chg_e6_rate", 32'(rate), 2);

    // Async reset with a pending result and a window in flight
    do_reset();
    window_len = 8'd4; spike = 1'b1; rate_ready = 1'b0; enable = 1'b1;
    tick(1);
    tick(6);
    check_eq("pre_arst_valid", 32'(rate_valid), 1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("arst_rate", 32'(rate), 0);
    check_eq("arst_valid", 32'(rate_valid), 0);
    check_eq("arst_ovf", 32'(overflow), 0);
    check_eq("arst_busy", 32'(busy), 0);
`ifdef SPIKE_ISI_EN
    check_eq("arst_isi", 32'(isi_min), 255);
`endif
    reset = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
